// File: rtl/rng_pkg.sv
// Shared constants and encodings for the card dealer and its decode helper.
package rng_pkg;

  localparam int DECK_SIZE      = 52;
  localparam int CARDS_PER_SUIT = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPIN,
    ST_SAMPLE,
    ST_PROBE,
    ST_PRESENT
  } state_e;

  typedef enum logic [1:0] {
    SUIT_CLUBS    = 2'd0,
    SUIT_DIAMONDS = 2'd1,
    SUIT_HEARTS   = 2'd2,
    SUIT_SPADES   = 2'd3
  } suit_e;

endpackage

// File: rtl/rng_card_decode.sv
// Combinational card index (1..52) to suit/rank using a compare/subtract chain.
module rng_card_decode
  import rng_pkg::*;
(
  input  logic [5:0] card,
  output logic [1:0] suit,
  output logic [3:0] rank
);

  localparam logic [5:0] SUIT1_BASE = 6'(CARDS_PER_SUIT);
  localparam logic [5:0] SUIT2_BASE = 6'(2 * CARDS_PER_SUIT);
  localparam logic [5:0] SUIT3_BASE = 6'(3 * CARDS_PER_SUIT);

  logic [5:0] idx;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    idx  = card - 6'd1;
    suit = SUIT_CLUBS;
    rank = 4'(idx + 6'd1);
    if (idx >= SUIT3_BASE) begin
      suit = SUIT_SPADES;
      rank = 4'(idx - SUIT3_BASE + 6'd1);
    end else if (idx >= SUIT2_BASE) begin
      suit = SUIT_HEARTS;
      rank = 4'(idx - SUIT2_BASE + 6'd1);
    end else if (idx >= SUIT1_BASE) begin
      suit = SUIT_DIAMONDS;
      rank = 4'(idx - SUIT1_BASE + 6'd1);
    end
  end

endmodule

// File: rtl/rng_card_dealer.sv
// Spins the external card counter, samples a draw, rejects dealt/invalid values
// by probing forward, and presents each unique card over valid/ready.
module rng_card_dealer #(
  parameter int MIN_SPIN  = 16,
  parameter int DECK_SIZE = rng_pkg::DECK_SIZE
) (
  input  logic       clk_dp_c_i,
  input  logic       rst_dp_c_i,
  input  logic       deal_req_i,
  input  logic       shuffle_i,
  input  logic [7:0] next_card_i,
  input  logic       card_ready_i,
  output logic       req_card_state_o,
  output logic       card_valid_o,
  output logic [5:0] card_o,
  output logic [1:0] suit_o,
  output logic [3:0] rank_o,
  output logic [5:0] cards_left_o,
  output logic       deck_empty_o,
  output logic       busy_o
);
  import rng_pkg::*;

  localparam logic [7:0] SPIN_LAST = 8'(MIN_SPIN - 1);
  localparam logic [7:0] DECK_LAST = 8'(DECK_SIZE);

  state_e               state;
  logic [7:0]           spin_cnt;
  logic [7:0]           cand;
  logic [DECK_SIZE:1]   dealt_mask;
  logic [5:0]           cand_idx;
  logic                 cand_ok;
  logic                 cand_free;
  logic [1:0]           dec_suit;
  logic [3:0]           dec_rank;

  assign cand_idx     = cand[5:0];
  assign cand_ok      = (cand != 8'd0) && (cand <= DECK_LAST);
  assign busy_o       = (state != ST_IDLE);
  assign deck_empty_o = (cards_left_o == 6'd0);

  always_comb begin
    cand_free = 1'b0;
    if (cand_ok) cand_free = !dealt_mask[cand_idx];
  end

  rng_card_decode u_decode (
    .card (cand_idx),
    .suit (dec_suit),
    .rank (dec_rank)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
    if (!rst_dp_c_i) begin
      state            <= ST_IDLE;
      spin_cnt         <= 8'd0;
      cand             <= 8'd0;
      // NOTE: the dealt flags are control state, not storage, so they are reset.
      dealt_mask       <= '0;
      cards_left_o     <= 6'(DECK_SIZE);
      req_card_state_o <= 1'b0;
      card_valid_o     <= 1'b0;
      card_o           <= 6'd0;
      suit_o           <= 2'd0;
      rank_o           <= 4'd0;
    end else if (shuffle_i) begin
      // Shuffle overrides everything, including a handshake in the same cycle.
      state            <= ST_IDLE;
      spin_cnt         <= 8'd0;
      dealt_mask       <= '0;
      cards_left_o     <= 6'(DECK_SIZE);
      req_card_state_o <= 1'b0;
      card_valid_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (deal_req_i && !deck_empty_o) begin
            state            <= ST_SPIN;
            spin_cnt         <= 8'd0;
            req_card_state_o <= 1'b1;
          end
        end
        ST_SPIN: begin
          if (spin_cnt != 8'hFF) spin_cnt <= spin_cnt + 8'd1;
          if (!deal_req_i && (spin_cnt >= SPIN_LAST)) begin
            state            <= ST_SAMPLE;
            req_card_state_o <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          cand  <= next_card_i;
          state <= ST_PROBE;
        end
        ST_PROBE: begin
          if (cand_free) begin
            dealt_mask[cand_idx] <= 1'b1;
            cards_left_o         <= cards_left_o - 6'd1;
            card_o               <= cand_idx;
            suit_o               <= dec_suit;
            rank_o               <= dec_rank;
            card_valid_o         <= 1'b1;
            state                <= ST_PRESENT;
          end else begin
            // Out-of-range values are treated like 0 and wrap to card 1.
            cand <= (!cand_ok || (cand == DECK_LAST)) ? 8'd1 : cand + 8'd1;
          end
        end
        ST_PRESENT: begin
          if (card_ready_i) begin
            card_valid_o <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_card_dealer.sv
// Self-checking bench for rng_card_dealer: deck model plus directed draws.
module tb_rng_card_dealer;

  localparam int MIN_SPIN = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       deal_req = 1'b0;
  logic       shuffle = 1'b0;
  logic       ready = 1'b0;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'd0;
  logic [7:0] cnt;
  logic [7:0] next_card;

  logic       req;
  logic       valid;
  logic [5:0] card;
  logic [1:0] suit;
  logic [3:0] rank;
  logic [5:0] cards_left;
  logic       empty;
  logic       busy;

  rng_card_dealer #(.MIN_SPIN(MIN_SPIN), .DECK_SIZE(52)) dut (
    .clk_dp_c_i       (clk),
    .rst_dp_c_i       (rst_n),
    .deal_req_i       (deal_req),
    .shuffle_i        (shuffle),
    .next_card_i      (next_card),
    .card_ready_i     (ready),
    .req_card_state_o (req),
    .card_valid_o     (valid),
    .card_o           (card),
    .suit_o           (suit),
    .rank_o           (rank),
    .cards_left_o     (cards_left),
    .deck_empty_o     (empty),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the upstream free-running counter: steps only while requested.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= 8'd0;
    else if (req) cnt <= (cnt >= 8'd52) ? 8'd1 : cnt + 8'd1;
  end
  assign next_card = force_en ? force_val : cnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Deck model: which cards are taken, how many remain, what the next card must be.
  bit   dealt    [1:52];
  bit   acc_seen [1:52];
  int   left     = 52;
  int   exp_card = 0;
  int   n_acc    = 0;
  bit   pending  = 1'b0;
  logic prev_req = 1'b0, prev_valid = 1'b0, shuf_prev = 1'b0;
  int   run_len  = 0, last_run = 0;

  function automatic int pick(input int v);
    int c;
    c = (v < 1 || v > 52) ? 1 : v;
    for (int k = 0; k < 52; k++) begin
      if (!dealt[c]) return c;
      c = (c == 52) ? 1 : c + 1;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || shuf_prev) begin
      for (int c = 1; c <= 52; c++) begin
        dealt[c]    = 1'b0;
        acc_seen[c] = 1'b0;
      end
      left    = 52;
      pending = 1'b0;
      n_acc   = 0;
    end else if (prev_req && !req) begin
      exp_card = pick(int'(next_card));
      pending  = 1'b1;
    end
    if (rst_n && valid && !prev_valid) begin
      check("valid_follows_draw", 32'(pending), 32'd1);
      if (exp_card >= 1 && exp_card <= 52) dealt[exp_card] = 1'b1;
      left    = left - 1;
      pending = 1'b0;
    end
    if (rst_n) begin
      check("cards_left", 32'(cards_left), 32'(left));
      check("deck_empty", 32'(empty), 32'(left == 0));
      if (valid) begin
        check("card", 32'(card), 32'(exp_card));
        check("suit", 32'(suit), 32'((exp_card - 1) / 13));
        check("rank", 32'(rank), 32'((exp_card - 1) % 13 + 1));
      end
      if (valid && ready && !shuffle && card >= 6'd1 && card <= 6'd52) begin
        check("unique", 32'(acc_seen[card]), 32'd0);
        acc_seen[card] = 1'b1;
        n_acc++;
      end
    end
    if (req) run_len++;
    else if (prev_req) begin
      last_run = run_len;
      run_len  = 0;
    end
    prev_req   = req;
    prev_valid = valid;
    shuf_prev  = shuffle;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic draw(input bit fen, input int fval, input int hold,
                      input int ec, input int es, input int er, input string name);
    int w;
    force_en  = fen;
    force_val = 8'(fval);
    deal_req  = 1'b1;
    repeat (hold) tick();
    deal_req = 1'b0;
    w = 0;
    while (!valid && w < 200) begin
      tick();
      w++;
    end
    check({name, "_valid"}, 32'(valid), 32'd1);
    if (ec > 0) begin
      check({name, "_card"}, 32'(card), 32'(ec));
      check({name, "_suit"}, 32'(suit), 32'(es));
      check({name, "_rank"}, 32'(rank), 32'(er));
    end
  endtask

  task automatic accept(input int delay, input string name);
    for (int k = 0; k < delay; k++) begin
      check({name, "_hold_valid"}, 32'(valid), 32'd1);
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({name, "_idle_valid"}, 32'(valid), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_shuffle();
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_card", 32'(card), 32'd0);
    check("rst_suit", 32'(suit), 32'd0);
    check("rst_rank", 32'(rank), 32'd0);
    check("rst_left", 32'(cards_left), 32'd52);
    check("rst_empty", 32'(empty), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Short request still spins MIN_SPIN cycles; first card of diamonds.
    draw(1'b1, 14, 3, 14, 1, 1, "t_min_spin");
    check("spin_len_min", 32'(last_run), 32'(MIN_SPIN));
    accept(0, "t_min_spin");
    check("left_after_14", 32'(cards_left), 32'd51);

    // 14 taken: one probe step to 15; long request stretches the spin.
    draw(1'b1, 14, 30, 15, 1, 2, "t_probe");
    check("spin_len_long", 32'(last_run), 32'd30);
    accept(0, "t_probe");
    check("left_after_15", 32'(cards_left), 32'd50);

    // Reset in the middle of a spin.
    force_val = 8'd14;
    deal_req  = 1'b1;
    repeat (5) tick();
    check("mid_spin_req", 32'(req), 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_req", 32'(req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_left", 32'(cards_left), 32'd52);
    deal_req = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    draw(1'b1, 14, 3, 14, 1, 1, "t_after_rst");
    accept(0, "t_after_rst");

    // Wrap boundaries: 52 -> 1, out-of-range -> 1 then probe, 0 -> 1.
    pulse_shuffle();
    check("shuffle_left", 32'(cards_left), 32'd52);
    draw(1'b1, 52, 3, 52, 3, 13, "t_card52");
    accept(0, "t_card52");
    draw(1'b1, 52, 3, 1, 0, 1, "t_wrap52");
    accept(0, "t_wrap52");
    draw(1'b1, 200, 3, 2, 0, 2, "t_over52");
    accept(0, "t_over52");
    pulse_shuffle();
    draw(1'b1, 0, 3, 1, 0, 1, "t_zero");
    accept(0, "t_zero");

    // Back-pressure: outputs held stable for 10 cycles.
    draw(1'b1, 26, 3, 26, 1, 13, "t_stall");
    accept(10, "t_stall");
    check("left_after_stall", 32'(cards_left), 32'd50);

    // Shuffle and ready together: the card is not delivered.
    draw(1'b1, 30, 3, 30, 2, 4, "t_shuf_ready");
    ready   = 1'b1;
    shuffle = 1'b1;
    tick();
    ready   = 1'b0;
    shuffle = 1'b0;
    check("shuf_ready_valid", 32'(valid), 32'd0);
    check("shuf_ready_busy", 32'(busy), 32'd0);
    check("shuf_ready_req", 32'(req), 32'd0);
    check("shuf_ready_left", 32'(cards_left), 32'd52);
    draw(1'b1, 30, 3, 30, 2, 4, "t_redeal");
    accept(0, "t_redeal");

    // Whole deck from the free-running counter.
    pulse_shuffle();
    force_en = 1'b0;
    for (int i = 0; i < 52; i++) begin
      draw(1'b0, 0, 3 + (i * 7) % 25, 0, 0, 0, "t_deal");
      accept(i % 3, "t_deal");
    end
    check("deck_accepts", 32'(n_acc), 32'd52);
    check("deck_left", 32'(cards_left), 32'd0);
    check("deck_empty_flag", 32'(empty), 32'd1);
    deal_req = 1'b1;
    repeat (20) begin
      tick();
      check("empty_no_spin", 32'(req), 32'd0);
      check("empty_not_busy", 32'(busy), 32'd0);
    end
    deal_req = 1'b0;
    pulse_shuffle();
    check("reshuffle_left", 32'(cards_left), 32'd52);
    check("reshuffle_empty", 32'(empty), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
